// File: rtl/value_change_recorder.sv
// Records each change of a sampled value with its cycle timestamp and queues it in a small FIFO.
// Latency: a change sampled in cycle t reaches the FIFO head in cycle t+1 when the FIFO is empty.
// Backpressure: a full FIFO that is not popped this cycle drops the change and flags it (overflow, drop_count).

// Generic show-ahead FIFO: the head is always visible; push/pop must only be asserted when legal.
// Latency: a write is visible at the head one cycle later.
// Backpressure: none internally; the caller qualifies push with full and pop with empty.
module vcr_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_dat,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;

    assign full  = (count == (AW+1)'(DEPTH));
    assign empty = (count == '0);
    assign head  = mem[rd_ptr];

    // Storage, pointers and occupancy; pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_dat;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push && !pop) begin
                count <= count + 1'b1;
            end else if (pop && !push) begin
                count <= count - 1'b1;
            end
        end
    end
endmodule

module value_change_recorder #(
    parameter int DATA_W = 2,
    parameter int TS_W   = 16,
    parameter int DEPTH  = 4,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sample_valid,
    input  logic [DATA_W-1:0] sample_data,
    output logic              rec_valid,
    input  logic              rec_ready,
    output logic [TS_W-1:0]   rec_time,
    output logic [DATA_W-1:0] rec_data,
    output logic              rec_first,
    output logic              overflow,
    output logic [CNT_W-1:0]  drop_count
);
    typedef struct packed {
        logic [TS_W-1:0]   ts;
        logic [DATA_W-1:0] data;
        logic              first;
    } rec_t;

    localparam int REC_W = $bits(rec_t);

    logic [TS_W-1:0]   ts;
    logic              have_last;
    logic [DATA_W-1:0] last_value;
    logic              change;
    logic              pop;
    logic              push;
    logic              drop;
    logic              fifo_full;
    logic              fifo_empty;
    rec_t              new_rec;
    logic [REC_W-1:0]  head_raw;
    rec_t              head_rec;

    // Event detection and push/drop decision; a same-cycle pop frees the slot a full FIFO needs.
    always_comb begin
        change        = sample_valid && (!have_last || (sample_data != last_value));
        pop           = rec_valid && rec_ready;
        push          = change && (!fifo_full || pop);
        drop          = change && fifo_full && !pop;
        new_rec.ts    = ts;
        new_rec.data  = sample_data;
        new_rec.first = !have_last;
    end

    // Free-running timestamp plus last-seen value; last_value tracks the true signal even on drops.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ts         <= '0;
            have_last  <= 1'b0;
            last_value <= '0;
        end else begin
            ts <= ts + 1'b1;
            if (change) begin
                have_last  <= 1'b1;
                last_value <= sample_data;
            end
        end
    end

    // Sticky overflow flag and saturating drop counter, cleared only by reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overflow   <= 1'b0;
            drop_count <= '0;
        end else if (drop) begin
            overflow <= 1'b1;
            if (drop_count != '1) begin
                drop_count <= drop_count + 1'b1;
            end
        end
    end

    vcr_fifo #(
        .WIDTH (REC_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (push),
        .push_dat (new_rec),
        .pop      (pop),
        .head     (head_raw),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

    assign head_rec  = rec_t'(head_raw);
    assign rec_valid = !fifo_empty;
    assign rec_time  = head_rec.ts;
    assign rec_data  = head_rec.data;
    assign rec_first = head_rec.first;
endmodule

// File: tb/tb_value_change_recorder.sv
// Self-checking bench: randomized and directed stimulus against a queue-based reference model.
// The DUT runs with a 4-bit timestamp so wrap-around occurs often.
// Inputs change and outputs are checked on the falling clock edge.
module tb_value_change_recorder;
    localparam int DW = 2;
    localparam int TW = 4;
    localparam int D  = 4;
    localparam int CW = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          sample_valid = 1'b0;
    logic [DW-1:0] sample_data = '0;
    logic          rec_valid;
    logic          rec_ready = 1'b0;
    logic [TW-1:0] rec_time;
    logic [DW-1:0] rec_data;
    logic          rec_first;
    logic          overflow;
    logic [CW-1:0] drop_count;

    always #5 clk = ~clk;

    value_change_recorder #(.DATA_W(DW), .TS_W(TW), .DEPTH(D), .CNT_W(CW)) dut (
        .clk          (clk),
        .rst          (rst),
        .sample_valid (sample_valid),
        .sample_data  (sample_data),
        .rec_valid    (rec_valid),
        .rec_ready    (rec_ready),
        .rec_time     (rec_time),
        .rec_data     (rec_data),
        .rec_first    (rec_first),
        .overflow     (overflow),
        .drop_count   (drop_count)
    );

    typedef struct {
        int t;
        int d;
        bit f;
    } mrec_t;

    mrec_t q[$];
    int    m_ts;
    bit    m_have;
    int    m_last;
    bit    m_ovf;
    int    m_drops;
    int    n_cmp = 0;
    int    n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_clear();
        q.delete();
        m_ts    = 0;
        m_have  = 1'b0;
        m_last  = 0;
        m_ovf   = 1'b0;
        m_drops = 0;
    endtask

    task automatic check_outputs();
        chk("rec_valid", 32'(rec_valid), 32'(q.size() != 0));
        if (q.size() != 0) begin
            chk("rec_time", 32'(rec_time), q[0].t);
            chk("rec_data", 32'(rec_data), q[0].d);
            chk("rec_first", 32'(rec_first), 32'(q[0].f));
        end
        chk("overflow", 32'(overflow), 32'(m_ovf));
        chk("drop_count", 32'(drop_count), m_drops);
    endtask

    // Called on a falling edge: check, drive inputs, advance the model, wait for next falling edge.
    task automatic step(input bit v, input int d, input bit r);
        bit    pop;
        bit    evt;
        bit    acc;
        mrec_t nr;
        check_outputs();
        sample_valid = v;
        sample_data  = d[DW-1:0];
        rec_ready    = r;
        pop = (q.size() != 0) && r;
        evt = v && (!m_have || d != m_last);
        acc = evt && ((q.size() < D) || pop);
        nr.t = m_ts;
        nr.d = d;
        nr.f = !m_have;
        if (evt && !acc) begin
            m_ovf = 1'b1;
            if (m_drops < (1 << CW) - 1) m_drops++;
        end
        if (pop) void'(q.pop_front());
        if (acc) q.push_back(nr);
        if (evt) begin
            m_have = 1'b1;
            m_last = d;
        end
        m_ts = (m_ts + 1) % (1 << TW);
        @(negedge clk);
    endtask

    // Asynchronous reset asserted between clock edges; effects must be immediate.
    task automatic do_reset();
        #1 rst = 1'b1;
        #1;
        chk("rst_valid", 32'(rec_valid), 0);
        chk("rst_overflow", 32'(overflow), 0);
        chk("rst_drops", 32'(drop_count), 0);
        model_clear();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        int cnt;
        model_clear();
        @(negedge clk);
        @(negedge clk);
        chk("init_valid", 32'(rec_valid), 0);
        chk("init_time", 32'(rec_time), 0);
        chk("init_data", 32'(rec_data), 0);
        chk("init_first", 32'(rec_first), 0);
        chk("init_overflow", 32'(overflow), 0);
        chk("init_drops", 32'(drop_count), 0);
        rst = 1'b0;

        // Basic capture of a 2-bit counter with a ready consumer.
        for (int i = 0; i < 5; i++) begin
            step(1'b1, i % 4, 1'b1);
            chk("basic_time", 32'(rec_time), i);
            chk("basic_data", 32'(rec_data), i % 4);
            chk("basic_first", 32'(rec_first), 32'(i == 0));
        end

        // Hold suppression: repeated values and invalid samples produce nothing.
        do_reset();
        step(1'b1, 1, 1'b1);
        chk("hold_t0", 32'(rec_time), 0);
        chk("hold_f0", 32'(rec_first), 1);
        step(1'b1, 1, 1'b1);
        chk("hold_none1", 32'(rec_valid), 0);
        step(1'b1, 1, 1'b1);
        step(1'b1, 2, 1'b1);
        chk("hold_t3", 32'(rec_time), 3);
        chk("hold_d3", 32'(rec_data), 2);
        chk("hold_f3", 32'(rec_first), 0);
        step(1'b0, 3, 1'b1);
        chk("hold_none4", 32'(rec_valid), 0);

        // Backpressure fill: six changes into four slots.
        do_reset();
        for (int i = 0; i < 6; i++) step(1'b1, i % 4, 1'b0);
        chk("bp_valid", 32'(rec_valid), 1);
        chk("bp_head", 32'(rec_time), 0);
        chk("bp_ovf", 32'(overflow), 1);
        chk("bp_drops", 32'(drop_count), 2);
        for (int k = 0; k < 4; k++) begin
            chk("bp_drain", 32'(rec_time), k);
            step(1'b1, 1, 1'b1);
        end
        chk("bp_empty", 32'(rec_valid), 0);

        // Full FIFO with a simultaneous pop accepts the new change.
        for (int i = 2; i < 6; i++) step(1'b1, i % 4, 1'b0);
        step(1'b1, 2, 1'b1);
        chk("fp_ovf", 32'(overflow), 1);
        chk("fp_drops", 32'(drop_count), 2);
        cnt = 0;
        for (int k = 0; k < 10; k++) begin
            if (rec_valid) cnt++;
            step(1'b0, 0, 1'b1);
        end
        chk("fp_occupancy", cnt, 4);

        // Reset with three records pending and overflow set.
        for (int i = 3; i < 8; i++) step(1'b1, i % 4, 1'b0);
        step(1'b0, 0, 1'b1);
        chk("mq_ovf", 32'(overflow), 1);
        do_reset();
        step(1'b1, 2, 1'b1);
        chk("mq_t", 32'(rec_time), 0);
        chk("mq_d", 32'(rec_data), 2);
        chk("mq_f", 32'(rec_first), 1);

        // Timestamp wrap: changes at ts 15 and the following cycle.
        do_reset();
        step(1'b1, 0, 1'b1);
        for (int k = 0; k < 20 && m_ts != 15; k++) step(1'b0, 0, 1'b1);
        step(1'b1, 1, 1'b1);
        chk("wrap_t15", 32'(rec_time), 15);
        step(1'b1, 2, 1'b1);
        chk("wrap_t0", 32'(rec_time), 0);
        chk("wrap_d0", 32'(rec_data), 2);

        // Drop counter saturation.
        do_reset();
        for (int k = 0; k < 300; k++) step(1'b1, k % 4, 1'b0);
        chk("sat_drops", 32'(drop_count), 255);

        // Randomized traffic with occasional resets.
        do_reset();
        for (int k = 0; k < 2000; k++) begin
            if ($urandom_range(0, 299) == 0) do_reset();
            step($urandom_range(0, 3) != 0, int'($urandom_range(0, 3)),
                 $urandom_range(0, 99) < ((k / 250) % 2 == 0 ? 70 : 25));
        end
        check_outputs();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
